// File: rtl/ysyx_23060221_lsu_pkg.sv
// Shared definitions for the load/store stage: access-size codes and FSM state encoding.
package ysyx_23060221_lsu_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/ysyx_23060221_lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and alignment check.
module ysyx_23060221_lsu_align
   import ysyx_23060221_lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_sdata,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_ldata,
   output logic        o_misalign
);

   logic [31:0] w_shift;

   assign w_shift = i_rdata >> {i_off, 3'b000};

   always_comb begin
      o_wdata    = i_sdata;
      o_wstrb    = 4'b0000;
      o_ldata    = w_shift;
      o_misalign = 1'b0;
      case (i_funct3)
         LS_B: begin
            o_wdata = {4{i_sdata[7:0]}};
            o_wstrb = 4'b0001 << i_off;
            o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
         end
         LS_BU: o_ldata = {24'h0, w_shift[7:0]};
         LS_H: begin
            o_wdata    = {2{i_sdata[15:0]}};
            o_wstrb    = 4'b0011 << i_off;
            o_ldata    = {{16{w_shift[15]}}, w_shift[15:0]};
            o_misalign = i_off[0];
         end
         LS_HU: begin
            o_ldata    = {16'h0, w_shift[15:0]};
            o_misalign = i_off[0];
         end
         LS_W: begin
            o_wstrb    = 4'b1111;
            o_misalign = |i_off;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_23060221_lsu.sv
// Load/store stage: accepts from execute, performs at most one memory access, holds result for writeback.
module ysyx_23060221_lsu
   import ysyx_23060221_lsu_pkg::*;
#(
   parameter int RSP_TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        EXU_valid,
   output logic        LSU_ready,
   input  logic [31:0] ex_res,
   input  logic [31:0] ex_wdata,
   input  logic        ex_ren,
   input  logic        ex_wen,
   input  logic [2:0]  ex_funct3,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rfwen,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        LSU_valid,
   input  logic        WBU_ready,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd,
   output logic        wb_rfwen,
   output logic [31:0] lsu_fwd_data,
   output logic        lsu_err
);

   localparam logic [7:0] LP_TO    = 8'(RSP_TIMEOUT);
   localparam bit         LP_TO_EN = (RSP_TIMEOUT != 0);

   lsu_state_e  r_state, w_state_nxt;
   logic [31:0] r_addr, r_wdata, r_wb_data;
   logic [3:0]  r_wstrb;
   logic [2:0]  r_funct3;
   logic [4:0]  r_wb_rd;
   logic        r_wen, r_rfwen, r_wb_rfwen, r_err;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_inc;
   logic        w_ready, w_accept, w_is_mem, w_rsp_done, w_timeout;
   logic [2:0]  w_al_funct3;
   logic [1:0]  w_al_off;
   logic [31:0] w_al_wdata, w_al_ldata;
   logic [3:0]  w_al_wstrb;
   logic        w_al_misalign;

   // The aligner looks at the incoming instruction while accepting and at the held one while waiting.
   assign w_al_funct3 = (r_state == ST_WAIT) ? r_funct3    : ex_funct3;
   assign w_al_off    = (r_state == ST_WAIT) ? r_addr[1:0] : ex_res[1:0];

   ysyx_23060221_lsu_align u_align (
      .i_funct3   (w_al_funct3),
      .i_off      (w_al_off),
      .i_sdata    (ex_wdata),
      .i_rdata    (mem_rsp_rdata),
      .o_wdata    (w_al_wdata),
      .o_wstrb    (w_al_wstrb),
      .o_ldata    (w_al_ldata),
      .o_misalign (w_al_misalign)
   );

   assign w_ready   = (r_state == ST_IDLE) | ((r_state == ST_DONE) & WBU_ready);
   assign w_accept  = EXU_valid & w_ready;
   assign w_is_mem  = ex_ren | ex_wen;
   assign w_cnt_inc = r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rsp_done  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_REQ: if (mem_req_ready) w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            // A response in the limit cycle still counts as a good completion.
            if (mem_rsp_valid) begin
               w_rsp_done  = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (LP_TO_EN && (w_cnt_inc == LP_TO)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: if (WBU_ready) w_state_nxt = ST_IDLE;
         default: ;
      endcase
      if (w_accept)
         w_state_nxt = (w_is_mem & ~w_al_misalign) ? ST_REQ : ST_DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_wstrb    <= 4'h0;
         r_funct3   <= 3'h0;
         r_wen      <= 1'b0;
         r_rfwen    <= 1'b0;
         r_wb_data  <= 32'h0;
         r_wb_rd    <= 5'h0;
         r_wb_rfwen <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= 8'h0;
      end else begin
         if (w_accept) begin
            r_addr     <= ex_res;
            r_wdata    <= w_al_wdata;
            r_wstrb    <= ex_wen ? w_al_wstrb : 4'h0;
            r_funct3   <= ex_funct3;
            r_wen      <= ex_wen;
            r_rfwen    <= ex_rfwen;
            r_wb_rd    <= ex_rd;
            r_wb_data  <= w_is_mem ? 32'h0 : ex_res;
            r_wb_rfwen <= w_is_mem ? 1'b0 : ex_rfwen;
            r_err      <= w_is_mem & w_al_misalign;
         end else if (w_rsp_done) begin
            r_wb_data  <= r_wen ? 32'h0 : w_al_ldata;
            r_wb_rfwen <= r_rfwen;
            r_err      <= 1'b0;
         end else if (w_timeout) begin
            r_wb_data  <= 32'h0;
            r_wb_rfwen <= 1'b0;
            r_err      <= 1'b1;
         end
         if (r_state == ST_REQ)       r_cnt <= 8'h0;
         else if (r_state == ST_WAIT) r_cnt <= w_cnt_inc;
      end
   end

   assign LSU_ready     = w_ready;
   assign mem_req_valid = (r_state == ST_REQ);
   assign mem_req_addr  = {r_addr[31:2], 2'b00};
   assign mem_req_we    = r_wen;
   assign mem_req_wdata = r_wdata;
   assign mem_req_wstrb = r_wstrb;
   assign LSU_valid     = (r_state == ST_DONE);
   assign wb_data       = r_wb_data;
   assign wb_rd         = r_wb_rd;
   assign wb_rfwen      = r_wb_rfwen;
   assign lsu_fwd_data  = r_wb_data;
   assign lsu_err       = r_err;

endmodule

// File: tb/tb_ysyx_23060221_lsu.sv
// Directed and randomized bench for the load/store stage against an arithmetic reference model.
module tb_ysyx_23060221_lsu;
   import ysyx_23060221_lsu_pkg::*;

   localparam int RSP_TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        EXU_valid = 1'b0, LSU_ready;
   logic [31:0] ex_res = '0, ex_wdata = '0;
   logic        ex_ren = 1'b0, ex_wen = 1'b0, ex_rfwen = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [4:0]  ex_rd = '0;
   logic        mem_req_valid, mem_req_we;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        LSU_valid, WBU_ready = 1'b1;
   logic [31:0] wb_data, lsu_fwd_data;
   logic [4:0]  wb_rd;
   logic        wb_rfwen, lsu_err;

   int errors = 0;
   int checks = 0;

   ysyx_23060221_lsu #(.RSP_TIMEOUT(RSP_TO)) dut (
      .clk(clk), .rst(rst), .EXU_valid(EXU_valid), .LSU_ready(LSU_ready),
      .ex_res(ex_res), .ex_wdata(ex_wdata), .ex_ren(ex_ren), .ex_wen(ex_wen),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_rfwen(ex_rfwen),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .LSU_valid(LSU_valid), .WBU_ready(WBU_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_rfwen(wb_rfwen), .lsu_fwd_data(lsu_fwd_data), .lsu_err(lsu_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: access size in bytes, byte offset, and the architectural effect of the instruction.
   function automatic void model(input bit ren, input bit wen, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input bit rfwen,
                                 output bit mis, output logic [31:0] m_wd, output logic [3:0] m_ws,
                                 output logic [31:0] res, output bit o_rfwen);
      int size, off;
      logic [31:0] v;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off  = int'(addr[1:0]);
      mis  = (ren | wen) && ((off % size) != 0);
      if (size == 1)      m_wd = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) m_wd = (wd & 32'hFFFF) * 32'h00010001;
      else                m_wd = wd;
      m_ws = 4'(((1 << size) - 1) << off);
      o_rfwen = rfwen;
      if (!(ren | wen)) res = addr;
      else if (mis) begin
         res = 32'h0;
         o_rfwen = 1'b0;
      end else if (wen) res = 32'h0;
      else begin
         v = rdata >> (8 * off);
         if (size < 4) begin
            v = v % (32'h1 << (8 * size));
            if (!f3[2] && v >= (32'h1 << (8 * size - 1))) v = v - (32'h1 << (8 * size));
         end
         res = v;
      end
   endfunction

   task automatic run_op(input bit ren, input bit wen, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                         input bit rfwen, input int req_dly, input int rsp_dly,
                         input logic [31:0] rdata, input bit respond);
      bit mis, e_rfwen, e_err;
      logic [31:0] m_wd, e_res;
      logic [3:0]  m_ws;
      int n;
      model(ren, wen, f3, res, wd, rdata, rfwen, mis, m_wd, m_ws, e_res, e_rfwen);
      e_err = mis;
      ex_ren = ren; ex_wen = wen; ex_funct3 = f3; ex_res = res; ex_wdata = wd;
      ex_rd = rd; ex_rfwen = rfwen; EXU_valid = 1'b1; WBU_ready = 1'b1;
      chk("ready_idle", LSU_ready, 1);
      @(posedge clk); #1;
      EXU_valid = 1'b0;
      if ((ren | wen) && !mis) begin
         for (int i = 0; i <= req_dly; i++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, {res[31:2], 2'b00});
            chk("req_we", mem_req_we, wen);
            chk("req_wstrb", mem_req_wstrb, wen ? m_ws : 4'h0);
            if (wen) chk("req_wdata", mem_req_wdata, m_wd);
            chk("valid_in_req", LSU_valid, 0);
            mem_req_ready = (i == req_dly);
            @(posedge clk); #1;
         end
         mem_req_ready = 1'b0;
         chk("req_dropped", mem_req_valid, 0);
         if (respond) begin
            for (int i = 0; i < rsp_dly; i++) begin
               chk("valid_in_wait", LSU_valid, 0);
               @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0; mem_rsp_rdata = $urandom;
         end else begin
            n = 0;
            while (LSU_valid !== 1'b1 && n < 20) begin
               @(posedge clk); #1;
               n++;
            end
            chk("timeout_cycles", n, RSP_TO);
            e_res = 32'h0; e_rfwen = 1'b0; e_err = 1'b1;
         end
      end
      chk("lsu_valid", LSU_valid, 1);
      chk("wb_data", wb_data, e_res);
      chk("fwd_data", lsu_fwd_data, e_res);
      chk("wb_rd", wb_rd, rd);
      chk("wb_rfwen", wb_rfwen, e_rfwen);
      chk("lsu_err", lsu_err, e_err);
      chk("no_req_done", mem_req_valid, 0);
      @(posedge clk); #1;
      chk("back_idle_valid", LSU_valid, 0);
      chk("back_idle_ready", LSU_ready, 1);
   endtask

   initial begin
      logic [2:0] lds [5];
      logic [2:0] sts [3];
      lds = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};
      sts = '{LS_B, LS_H, LS_W};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", LSU_ready, 1);
      chk("rst_valid", LSU_valid, 0);
      chk("rst_req", mem_req_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_err", lsu_err, 0);
      chk("rst_rfwen", wb_rfwen, 0);

      // ALU passthrough
      run_op(0, 0, LS_W, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 32'h0, 1);
      // lb / lbu at offset 3 with delayed ready and response
      run_op(1, 0, LS_B,  32'h80000003, 32'h0, 5'd6, 1, 2, 3, 32'h80FF7F01, 1);
      run_op(1, 0, LS_BU, 32'h80000003, 32'h0, 5'd6, 1, 2, 3, 32'h80FF7F01, 1);
      // sh upper half
      run_op(0, 1, LS_H, 32'h80000002, 32'hABCD1234, 5'd0, 0, 1, 1, 32'h0, 1);
      // misaligned lw
      run_op(1, 0, LS_W, 32'h80000001, 32'h0, 5'd9, 1, 0, 0, 32'h0, 1);
      // response exactly in the limit cycle wins
      run_op(1, 0, LS_HU, 32'h80000006, 32'h0, 5'd3, 1, 0, RSP_TO - 1, 32'hBEEF1234, 1);
      // timeout, late response ignored, then a normal ALU op
      run_op(1, 0, LS_W, 32'h80000008, 32'h0, 5'd10, 1, 0, 0, 32'h0, 0);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h55AA55AA;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      chk("late_rsp_valid", LSU_valid, 0);
      chk("late_rsp_ready", LSU_ready, 1);
      run_op(0, 0, LS_B, 32'hCAFEF00D, 32'h0, 5'd11, 1, 0, 0, 32'h0, 1);

      // Back-to-back with writeback stall
      WBU_ready = 1'b0;
      ex_ren = 0; ex_wen = 0; ex_res = 32'h1111AAAA; ex_rd = 5'd12; ex_rfwen = 1; EXU_valid = 1;
      @(posedge clk); #1;
      chk("b2b_first_valid", LSU_valid, 1);
      ex_res = 32'h2222BBBB; ex_rd = 5'd13;
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", LSU_ready, 0);
         chk("stall_data", wb_data, 32'h1111AAAA);
         @(posedge clk); #1;
      end
      WBU_ready = 1'b1;
      #1 chk("release_ready", LSU_ready, 1);
      @(posedge clk); #1;
      EXU_valid = 1'b0;
      chk("b2b_second_valid", LSU_valid, 1);
      chk("b2b_second_data", wb_data, 32'h2222BBBB);
      chk("b2b_second_rd", wb_rd, 13);
      @(posedge clk); #1;
      chk("b2b_idle", LSU_valid, 0);

      // Reset while waiting for a response
      ex_ren = 1; ex_wen = 0; ex_funct3 = LS_W; ex_res = 32'h80000010; ex_rd = 5'd7; ex_rfwen = 1;
      EXU_valid = 1;
      @(posedge clk); #1;
      EXU_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      chk("wait_before_rst", LSU_valid, 0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("abort_ready", LSU_ready, 1);
      chk("abort_valid", LSU_valid, 0);
      chk("abort_req", mem_req_valid, 0);
      chk("abort_addr", mem_req_addr, 0);
      chk("abort_wb_rd", wb_rd, 0);
      chk("abort_wb_data", wb_data, 0);
      chk("abort_err", lsu_err, 0);

      // Randomized mix
      for (int k = 0; k < 40; k++) begin
         int kind;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         a = 32'h80000000 | ($urandom & 32'h0000FFFF);
         if (kind == 0)
            run_op(0, 0, LS_W, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, 32'h0, 1);
         else if (kind == 1)
            run_op(1, 0, lds[$urandom_range(0, 4)], a, 32'h0, 5'($urandom), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, RSP_TO - 1), $urandom, 1);
         else
            run_op(0, 1, sts[$urandom_range(0, 2)], a, $urandom, 5'($urandom), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, RSP_TO - 1), $urandom, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_23060221_lsu.md
Name: ysyx_23060221_lsu

Overview:
Load/store stage directly downstream of the execute stage. It accepts one instruction per handshake from the execute stage: the ALU result, store data, memory opcode and writeback tag. Non-memory instructions pass straight through. Loads and stores issue one request on a simple valid/ready memory port, wait for the response, and align/extend the data. Results are then held for the writeback stage behind a valid/ready handshake, and the held value is exported for forwarding.

Parameters:
RSP_TIMEOUT, 255, max cycles waiting for mem_rsp_valid before the access is flagged as an error (8-bit counter; 0 disables the timeout).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
EXU_valid  in  1  execute stage offers an instruction
LSU_ready  out  1  this stage can accept this cycle
ex_res  in  32  ALU result (address for memory ops, else the writeback value)
ex_wdata  in  32  store data (rs2)
ex_ren  in  1  instruction is a load
ex_wen  in  1  instruction is a store
ex_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
ex_rd  in  5  destination register
ex_rfwen  in  1  register write enable
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  word-aligned address {ex_res[31:2],2'b00}
mem_req_we  out  1  1 = write
mem_req_wdata  out  32  lane-shifted store data
mem_req_wstrb  out  4  byte strobes (0 for reads)
mem_rsp_valid  in  1  response valid (one-cycle pulse; always accepted)
mem_rsp_rdata  in  32  read word
LSU_valid  out  1  result valid toward writeback
WBU_ready  in  1  writeback accepts
wb_data  out  32  result (load data or ALU result)
wb_rd  out  5  held rd
wb_rfwen  out  1  held register write enable (forced 0 on error)
lsu_fwd_data  out  32  equals wb_data; forwarding source for the execute stage
lsu_err  out  1  misaligned access or timeout; valid with LSU_valid

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE and zeroes all outputs and registers. LSU_ready resets to 1.
- LSU_ready = (state==IDLE) | (state==DONE & WBU_ready). Accept occurs on EXU_valid & LSU_ready. On accept, capture all ex_* inputs.
- Accept with neither ren nor wen, or with a misaligned access:
  - go to DONE next cycle.
  - wb_data = ex_res, or 0 if misaligned.
  - Latency is 1 cycle.
- Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - Set lsu_err=1 and wb_rfwen=0.
  - No memory request is issued.
- Accept of an aligned memory op: go to REQ.
  - mem_req_valid=1, with addr/we/wdata/wstrb stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready, go to WAIT. The request never drops before it is accepted.
- Store lanes: sb gives wdata = {4{b}} and wstrb = 0001<<addr[1:0]. sh gives {2{h}} and 0011<<addr[1:0]. sw gives the full word and 1111.
- WAIT: on mem_rsp_valid, go to DONE.
  - Load data: shift rdata right by 8*addr[1:0], then sign- or zero-extend per funct3.
  - Store: wb_data = 0, wb_rfwen = held value (normally 0).
- WAIT counter: cleared on entering WAIT, increments each cycle. If it reaches RSP_TIMEOUT (nonzero) before a response, go to DONE with lsu_err=1, wb_rfwen=0, wb_data=0. A response arriving later in IDLE/DONE is ignored.
- A response in the same cycle the counter hits the limit wins: no error.
- DONE: LSU_valid=1 and outputs held. On WBU_ready:
  - if EXU_valid, accept the next instruction in the same cycle (back-to-back, no bubble);
  - else go to IDLE.
- LSU_valid=0 in IDLE/REQ/WAIT. lsu_fwd_data always mirrors wb_data.
- rst in REQ or WAIT aborts immediately: mem_req_valid drops the next cycle, and there is no retry.
- mem_rsp_valid in IDLE, REQ or DONE is ignored.
- Only one access is outstanding at a time.

Decomposition:
- Shared package holds:
  - funct3 constants: LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101;
  - the FSM state encoding.
- One natural sub-module: ysyx_23060221_lsu_align. It is combinational and computes wdata/wstrb for stores, load extraction/extension and the misalign flag from funct3, addr[1:0] and data. The top level holds the FSM, counter and pipeline registers.

Test Plan:
1. ALU op: ex_res=0x1234, rfwen=1, rd=5, WBU_ready=1 -> LSU_valid next cycle, wb_data=0x1234, wb_rd=5, no mem_req_valid.
2. lb at 0x80000003, mem returns 0x80FF7F01 after 3 cycles, req_ready delayed 2 cycles -> addr=0x80000000, req held stable until ready, wb_data=0xFFFFFF80. Repeat as lbu -> 0x00000080.
3. sh 0xABCD1234 at 0x80000002 -> wdata=0x12341234, wstrb=1100, we=1; after response LSU_valid=1, wb_rfwen=0.
4. lw at 0x80000001 -> no request, LSU_valid after 1 cycle, lsu_err=1, wb_rfwen=0, wb_data=0.
5. RSP_TIMEOUT=4, lw with no response -> LSU_valid 4 cycles after entering WAIT with lsu_err=1. A late response is ignored, and a following ALU op completes normally.
6. Back-to-back ALU ops with WBU_ready held 0 for 3 cycles, then 1 -> LSU_ready=0 while stalled, wb_data held. The second op is accepted in the release cycle and there is no bubble. Assert rst during WAIT -> IDLE, all outputs 0, LSU_ready=1 next cycle.
